// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel valid/ready stream mux with fixed or round-robin select and registered output
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode_rr,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;
    logic             hi_found;
    logic             lo_found;
    logic             grant_valid;
    logic             load_en;
    logic [WIDTH-1:0] grant_data;

    assign load_en = !out_valid || out_ready;

    always_comb begin
        hi_found    = 1'b0;
        lo_found    = 1'b0;
        hi_idx      = '0;
        lo_idx      = '0;
        grant_valid = 1'b0;
        grant       = '0;
        grant_data  = '0;
        in_ready    = '0;

        // Circular scan from ptr+1: lowest requester above ptr wins, else lowest at or below ptr.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                if (SEL_W'(i) > ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_W'(i);
                end
            end
        end

        if (mode_rr) begin
            if (hi_found) begin
                grant_valid = 1'b1;
                grant       = hi_idx;
            end else if (lo_found) begin
                grant_valid = 1'b1;
                grant       = lo_idx;
            end
        end else begin
            // Out-of-range sel matches no channel and therefore never grants.
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant       = sel;
                end
            end
        end

        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
            in_ready[i] = !rst && load_en && grant_valid && (grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= PTR_RST;
        end else if (load_en) begin
            if (grant_valid) begin
                out_data  <= grant_data;
                out_chan  <= grant;
                out_valid <= 1'b1;
                if (mode_rr) begin
                    ptr <= grant;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        mode_rr;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        m2;
    logic [1:0]  s2;
    logic [47:0] d2;
    logic [2:0]  v2;
    logic [2:0]  ir2;
    logic [15:0] od2;
    logic [1:0]  oc2;
    logic        ov2;
    logic        or2;

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .mode_rr(mode_rr), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(16), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .mode_rr(m2), .sel(s2),
        .in_data(d2), .in_valid(v2), .in_ready(ir2),
        .out_data(od2), .out_chan(oc2), .out_valid(ov2),
        .out_ready(or2)
    );

    int applied = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       m;
        logic [1:0] sel;
        logic [3:0] v;
        logic       r;
        logic [3:0] ir;
        logic       ov;
        logic [7:0] od;
        logic [1:0] oc;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic m, logic [1:0] s, logic [3:0] v, logic r,
                                logic [3:0] ir, logic ov, logic [7:0] od, logic [1:0] oc);
        vec_t t;
        t.m = m; t.sel = s; t.v = v; t.r = r; t.ir = ir; t.ov = ov; t.od = od; t.oc = oc;
        return t;
    endfunction

    // Reference model state: registered output and the last round-robin winner.
    int ev, ed, ec, last;

    initial begin
        int le, gv, g, c, exp_ir;

        tbl[0]  = mk(0, 2, 4'b1111, 1, 4'b0100, 1, 8'hC2, 2);
        tbl[1]  = mk(0, 3, 4'b1111, 1, 4'b1000, 1, 8'hD3, 3);
        tbl[2]  = mk(1, 0, 4'b1111, 1, 4'b0001, 1, 8'hA0, 0);
        tbl[3]  = mk(1, 0, 4'b1111, 1, 4'b0010, 1, 8'hB1, 1);
        tbl[4]  = mk(1, 0, 4'b1111, 1, 4'b0100, 1, 8'hC2, 2);
        tbl[5]  = mk(1, 0, 4'b1111, 1, 4'b1000, 1, 8'hD3, 3);
        tbl[6]  = mk(1, 0, 4'b1111, 1, 4'b0001, 1, 8'hA0, 0);
        tbl[7]  = mk(1, 0, 4'b1111, 1, 4'b0010, 1, 8'hB1, 1);
        tbl[8]  = mk(1, 0, 4'b1111, 1, 4'b0100, 1, 8'hC2, 2);
        tbl[9]  = mk(1, 0, 4'b1111, 1, 4'b1000, 1, 8'hD3, 3);
        tbl[10] = mk(1, 0, 4'b1010, 1, 4'b0010, 1, 8'hB1, 1);
        tbl[11] = mk(1, 0, 4'b1010, 1, 4'b1000, 1, 8'hD3, 3);
        tbl[12] = mk(1, 0, 4'b1010, 1, 4'b0010, 1, 8'hB1, 1);
        tbl[13] = mk(1, 0, 4'b1010, 1, 4'b1000, 1, 8'hD3, 3);
        tbl[14] = mk(1, 0, 4'b0000, 1, 4'b0000, 0, 8'hD3, 3);
        tbl[15] = mk(0, 1, 4'b0000, 1, 4'b0000, 0, 8'hD3, 3);
        tbl[16] = mk(0, 0, 4'b0000, 0, 4'b0000, 0, 8'hD3, 3);

        rst = 1'b1;
        mode_rr = 1'b1; sel = 2'd1; in_data = 32'h1234_5678; in_valid = 4'b1111; out_ready = 1'b1;
        m2 = 1'b1; s2 = 2'd0; d2 = 48'h0003_0002_0001; v2 = 3'b111; or2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_chan", 32'(out_chan), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_in_ready3", 32'(ir2), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven: fixed select, round-robin fairness, sparse valids, drain.
        in_data = 32'hD3C2_B1A0;
        v2 = 3'b000;
        for (int i = 0; i < 17; i++) begin
            mode_rr = tbl[i].m; sel = tbl[i].sel; in_valid = tbl[i].v; out_ready = tbl[i].r;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
            chk($sformatf("tbl%0d_out_chan", i), 32'(out_chan), 32'(tbl[i].oc));
            @(negedge clk);
        end

        // Backpressure: hold 5A while rr inputs wait; ptr (last=3) must not advance.
        mode_rr = 1'b0; sel = 2'd1; in_data = 32'h4433_5A11; in_valid = 4'b0010; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_load", 32'(out_data), 32'h5A);
        @(negedge clk);
        mode_rr = 1'b1; in_data = 32'h4433_2211; in_valid = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_out_data", i), 32'(out_data), 32'h5A);
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'h1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'h1);
        chk("bp_release_data", 32'(out_data), 32'h11);
        chk("bp_release_chan", 32'(out_chan), 32'h0);
        @(posedge clk); #1;
        chk("bp_next_chan", 32'(out_chan), 32'h1);
        chk("bp_next_data", 32'(out_data), 32'h22);

        // Asynchronous reset while a word is held.
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_data", 32'(out_data), 32'h0);
        chk("async_rst_chan", 32'(out_chan), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Three-channel, 16-bit instance: out-of-range sel, then round-robin cycle.
        m2 = 1'b0; s2 = 2'd3; d2 = 48'hCCCC_BBBB_AAAA; v2 = 3'b111; or2 = 1'b1;
        #1;
        chk("c3_oor_in_ready", 32'(ir2), 32'h0);
        @(posedge clk); #1;
        chk("c3_oor_valid", 32'(ov2), 32'h0);
        @(negedge clk);
        m2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("c3_rr%0d_chan", i), 32'(oc2), 32'(i % 3));
            chk($sformatf("c3_rr%0d_data", i), 32'(od2), 32'h0000AAAA + 32'((i % 3) * 32'h1111));
            chk($sformatf("c3_rr%0d_valid", i), 32'(ov2), 32'h1);
        end
        @(negedge clk);
        v2 = 3'b000;

        // Randomized run against the reference model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ev = 0; ed = 0; ec = 0; last = 3;
        for (int n = 0; n < 300; n++) begin
            mode_rr   = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            le = (ev == 0 || out_ready) ? 1 : 0;
            gv = 0; g = 0;
            if (le != 0) begin
                if (mode_rr) begin
                    for (int k = 1; k <= 4; k++) begin
                        c = (last + k) % 4;
                        if (gv == 0 && in_valid[c]) begin
                            gv = 1; g = c;
                        end
                    end
                end else if (in_valid[sel]) begin
                    gv = 1; g = int'(sel);
                end
            end
            exp_ir = (gv != 0) ? (1 << g) : 0;
            #1;
            chk($sformatf("rnd%0d_in_ready", n), 32'(in_ready), 32'(exp_ir));
            @(posedge clk); #1;
            if (le != 0) begin
                if (gv != 0) begin
                    ed = int'((in_data >> (g * 8)) & 32'hFF);
                    ec = g;
                    ev = 1;
                    if (mode_rr) last = g;
                end else begin
                    ev = 0;
                end
            end
            chk($sformatf("rnd%0d_out_valid", n), 32'(out_valid), 32'(ev));
            chk($sformatf("rnd%0d_out_data", n), 32'(out_data), 32'(ed));
            chk($sformatf("rnd%0d_out_chan", n), 32'(out_chan), 32'(ec));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input channel and on the single output.
- Generalises the team's 1-bit 2x1 mux in three ways: channel count, data width, and a registered output stage.
- Two selection modes:
  - fixed: an external `sel` picks the channel.
  - round-robin: a fair arbiter picks the channel.
- Sits between multiple producers and one shared consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels (≥2).
- SEL_W, $clog2(CHANNELS), width of channel index. Derived; do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mode_rr  input  1  0 = fixed select via `sel`, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode_rr=0.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready (combinational).
- out_data  output  WIDTH  registered output data.
- out_chan  output  SEL_W  index of the channel that produced out_data (registered).
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=CHANNELS-1, so channel 0 has first priority.
  - Asserting rst mid-transfer drops the held word immediately; no partial state survives.
- Output stage:
  - One-entry register.
  - load_en = !out_valid || out_ready.
  - Output handshake completes when out_valid && out_ready.
- Grant (combinational, evaluated only when load_en=1):
  - mode_rr=0: grant = sel if sel < CHANNELS and in_valid[sel]=1; otherwise no grant. Other channels' valids are ignored.
  - mode_rr=1: grant = first i with in_valid[i]=1, scanning circularly from ptr+1 through ptr (wraps CHANNELS-1 → 0). No grant if in_valid is all zeros.
- in_ready[i] = load_en && grant_valid && (grant==i). At most one bit is set.
- in_ready never depends on in_valid of the same channel except through grant selection; no combinational path from out_ready to out_data.
- On a grant at a clock edge:
  - out_data ← in_data[grant].
  - out_chan ← grant.
  - out_valid ← 1.
  - If mode_rr=1, ptr ← grant.
- If load_en=1 with no grant: out_valid ← 0; out_data and out_chan hold.
- If load_en=0 (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold stable; all in_ready=0.
- Latency and throughput:
  - An input word accepted at edge k appears at the output after edge k (1 cycle).
  - Back-to-back: one word per cycle when out_ready stays high.
- Fixed mode leaves ptr unchanged.
- Mode changes take effect at the next grant evaluation and do not disturb the held output word.
- Fairness in round-robin mode: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0,… and no channel waits more than CHANNELS-1 grants.
- Out-of-range `sel` (non-power-of-2 CHANNELS): no grant; out_valid drops after the current word drains.
- Input channels must hold data/valid stable until in_ready; the block does not check this.

Test Plan (WIDTH=8, CHANNELS=4 unless stated):
- Reset: hold rst=1 with arbitrary inputs → out_valid=0, out_data=8'h00, out_chan=0, in_ready=4'b0000. Assert rst asynchronously mid-cycle while out_valid=1 → out_valid falls without waiting for a clock edge.
- Fixed mode, single channel: mode_rr=0, sel=2, in_valid=4'b1111, in_data = {8'hD3,8'hC2,8'hB1,8'hA0}, out_ready=1 → in_ready=4'b0100; next cycle out_data=8'hC2, out_chan=2, out_valid=1. sel=3 on the following cycle → out_data=8'hD3.
- Round-robin fairness: mode_rr=1, in_valid=4'b1111 for 8 cycles, out_ready=1 → out_chan sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1010 → 1,3,1,3 (wrap from 3 skips 0).
- Backpressure: out_valid=1 with out_data=8'h5A, out_ready=0 for 3 cycles → out_data stays 8'h5A, in_ready=4'b0000, ptr frozen. out_ready=1 → new word loads on the same edge the old one is consumed; no bubble, no duplicate.
- Empty and drain: in_valid=4'b0000, out_ready=1 → out_valid=0 one cycle after the last word is consumed; out_data holds its last value.
- Generalisation: CHANNELS=3, WIDTH=16, mode_rr=0, sel=3 → no grant and out_valid=0. Then mode_rr=1, in_valid=3'b111 → out_chan cycles 0,1,2,0.
